// File: rtl/cob_timing_arbiter.sv
// cob_timing_arbiter: merges COB timing streams A and B through per-stream
// FIFOs and a round-robin arbiter. Define COB_ARB_OVFL_CNT_EN to build the drop counters.
module cob_timing_arbiter #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sysClk125,
    input  logic                 sysClk125Rst,
    input  logic [9:0]           rxDataA,
    input  logic                 rxDataAEn,
    input  logic [9:0]           rxDataB,
    input  logic                 rxDataBEn,
    output logic [9:0]           txData,
    output logic                 txDataEn,
    input  logic                 txReady,
    output logic                 lastGrantB,
    output logic                 fifoAFull,
    output logic                 fifoBFull,
    output logic [CNT_WIDTH-1:0] ovflCntA,
    output logic [CNT_WIDTH-1:0] ovflCntB
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [9:0]    memA_q [DEPTH];
    logic [9:0]    memB_q [DEPTH];
    logic [AW-1:0] wrPtrA_q, rdPtrA_q;
    logic [AW-1:0] wrPtrB_q, rdPtrB_q;
    logic [CW-1:0] cntA_q, cntA_d;
    logic [CW-1:0] cntB_q, cntB_d;
    logic [9:0]    txData_q;
    logic          txDataEn_q;
    logic          lastGrantB_q;
    logic          fullA_q, fullB_q;

    logic          neA, neB;
    logic          popA, popB;
    logic          wrA, wrB;
    logic [9:0]    popWord;

    assign neA = (cntA_q != '0);
    assign neB = (cntB_q != '0);

    // Round-robin pick using counts from before the edge; A wins ties after B.
    always_comb begin
        popA = 1'b0;
        popB = 1'b0;
        if (txReady) begin
            if (neA && neB) begin
                popA = lastGrantB_q;
                popB = !lastGrantB_q;
            end else begin
                popA = neA;
                popB = neB;
            end
        end
    end

    // A full FIFO still accepts a word when it is popped on the same edge.
    assign wrA = rxDataAEn && ((cntA_q != FULL_CNT) || popA);
    assign wrB = rxDataBEn && ((cntB_q != FULL_CNT) || popB);

    assign popWord = popA ? memA_q[rdPtrA_q] : memB_q[rdPtrB_q];

    // Next occupancy of each FIFO: moves by at most one per edge.
    always_comb begin
        cntA_d = cntA_q;
        cntB_d = cntB_q;
        if (wrA && !popA) begin
            cntA_d = cntA_q + 1'b1;
        end else if (!wrA && popA) begin
            cntA_d = cntA_q - 1'b1;
        end
        if (wrB && !popB) begin
            cntB_d = cntB_q + 1'b1;
        end else if (!wrB && popB) begin
            cntB_d = cntB_q - 1'b1;
        end
    end

    // FIFO storage; contents are meaningless once reset clears the counts.
    always_ff @(posedge sysClk125) begin
        if (!sysClk125Rst && wrA) begin
            memA_q[wrPtrA_q] <= rxDataA;
        end
        if (!sysClk125Rst && wrB) begin
            memB_q[wrPtrB_q] <= rxDataB;
        end
    end

    // Pointers, counts, flags and the registered output word.
    always_ff @(posedge sysClk125) begin
        if (sysClk125Rst) begin
            wrPtrA_q     <= '0;
            rdPtrA_q     <= '0;
            wrPtrB_q     <= '0;
            rdPtrB_q     <= '0;
            cntA_q       <= '0;
            cntB_q       <= '0;
            txData_q     <= '0;
            txDataEn_q   <= 1'b0;
            lastGrantB_q <= 1'b1;
            fullA_q      <= 1'b0;
            fullB_q      <= 1'b0;
        end else begin
            if (wrA) wrPtrA_q <= wrPtrA_q + 1'b1;
            if (wrB) wrPtrB_q <= wrPtrB_q + 1'b1;
            if (popA) rdPtrA_q <= rdPtrA_q + 1'b1;
            if (popB) rdPtrB_q <= rdPtrB_q + 1'b1;
            cntA_q     <= cntA_d;
            cntB_q     <= cntB_d;
            fullA_q    <= (cntA_d == FULL_CNT);
            fullB_q    <= (cntB_d == FULL_CNT);
            txDataEn_q <= popA || popB;
            if (popA || popB) begin
                txData_q     <= popWord;
                lastGrantB_q <= popB;
            end
        end
    end

`ifdef COB_ARB_OVFL_CNT_EN
    logic                 dropA, dropB;
    logic [CNT_WIDTH-1:0] ovflA_q, ovflB_q;

    assign dropA = rxDataAEn && !wrA;
    assign dropB = rxDataBEn && !wrB;

    // Saturating count of words dropped at a full FIFO.
    always_ff @(posedge sysClk125) begin
        if (sysClk125Rst) begin
            ovflA_q <= '0;
            ovflB_q <= '0;
        end else begin
            if (dropA && !(&ovflA_q)) ovflA_q <= ovflA_q + 1'b1;
            if (dropB && !(&ovflB_q)) ovflB_q <= ovflB_q + 1'b1;
        end
    end

    assign ovflCntA = ovflA_q;
    assign ovflCntB = ovflB_q;
`else
    assign ovflCntA = '0;
    assign ovflCntB = '0;
`endif

    assign txData     = txData_q;
    assign txDataEn   = txDataEn_q;
    assign lastGrantB = lastGrantB_q;
    assign fifoAFull  = fullA_q;
    assign fifoBFull  = fullB_q;

endmodule

// File: tb/tb_cob_timing_arbiter.sv
// tb_cob_timing_arbiter: directed scoreboard bench for cob_timing_arbiter.
// Expected words are queued at stimulus time and matched as txDataEn fires.
module tb_cob_timing_arbiter;

`ifdef COB_ARB_OVFL_CNT_EN
    localparam int EXP_OVFL = 2;
`else
    localparam int EXP_OVFL = 0;
`endif

    logic        sysClk125 = 1'b0;
    logic        sysClk125Rst;
    logic [9:0]  rxDataA;
    logic        rxDataAEn;
    logic [9:0]  rxDataB;
    logic        rxDataBEn;
    logic [9:0]  txData;
    logic        txDataEn;
    logic        txReady;
    logic        lastGrantB;
    logic        fifoAFull;
    logic        fifoBFull;
    logic [15:0] ovflCntA;
    logic [15:0] ovflCntB;

    int checks = 0;
    int errors = 0;
    logic [9:0] expQ[$];

    cob_timing_arbiter #(.DEPTH(4), .CNT_WIDTH(16)) dut (
        .sysClk125    (sysClk125),
        .sysClk125Rst (sysClk125Rst),
        .rxDataA      (rxDataA),
        .rxDataAEn    (rxDataAEn),
        .rxDataB      (rxDataB),
        .rxDataBEn    (rxDataBEn),
        .txData       (txData),
        .txDataEn     (txDataEn),
        .txReady      (txReady),
        .lastGrantB   (lastGrantB),
        .fifoAFull    (fifoAFull),
        .fifoBFull    (fifoBFull),
        .ovflCntA     (ovflCntA),
        .ovflCntB     (ovflCntB)
    );

    always #4 sysClk125 = ~sysClk125;

    // Scoreboard: every output pulse must match the oldest queued word.
    always @(negedge sysClk125) begin
        if (txDataEn === 1'b1) begin
            checks++;
            assert (expQ.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed %0h expected none", txData);
            end
            if (expQ.size() != 0) begin
                logic [9:0] e;
                e = expQ.pop_front();
                checks++;
                assert (txData === e) else begin
                    errors++;
                    $error("FAIL sb_word: observed %0h expected %0h", txData, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge sysClk125);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sysClk125Rst = 1'b1;
        step();
        sysClk125Rst = 1'b0;
        expQ.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_txData"}, txData, 0);
        chk({tag, "_txDataEn"}, txDataEn, 0);
        chk({tag, "_lastGrantB"}, lastGrantB, 1);
        chk({tag, "_fullA"}, fifoAFull, 0);
        chk({tag, "_fullB"}, fifoBFull, 0);
        chk({tag, "_ovflA"}, ovflCntA, 0);
        chk({tag, "_ovflB"}, ovflCntB, 0);
    endtask

    initial begin
        sysClk125Rst = 1'b0;
        rxDataA = '0; rxDataAEn = 1'b0;
        rxDataB = '0; rxDataBEn = 1'b0;
        txReady = 1'b0;
        do_reset();
        chk_reset_state("rst0");

        // Single A word, latency 2 edges.
        txReady = 1'b1;
        rxDataA = 10'h155; rxDataAEn = 1'b1;
        expQ.push_back(10'h155);
        step();
        rxDataAEn = 1'b0;
        chk("single_en_e0", txDataEn, 0);
        step();
        chk("single_en_e1", txDataEn, 1);
        chk("single_data", txData, 10'h155);
        chk("single_grant", lastGrantB, 0);
        step();
        chk("single_en_e2", txDataEn, 0);
        chk("single_hold", txData, 10'h155);

        // Simultaneous A/B pairs; A wins the tie after reset and after B.
        do_reset();
        txReady = 1'b1;
        for (int p = 0; p < 2; p++) begin
            rxDataA = 10'h001; rxDataAEn = 1'b1;
            rxDataB = 10'h002; rxDataBEn = 1'b1;
            expQ.push_back(10'h001);
            expQ.push_back(10'h002);
            step();
            rxDataAEn = 1'b0; rxDataBEn = 1'b0;
            step();
            chk("pair_first", txData, 10'h001);
            chk("pair_first_grant", lastGrantB, 0);
            step();
            chk("pair_second", txData, 10'h002);
            chk("pair_second_en", txDataEn, 1);
            chk("pair_second_grant", lastGrantB, 1);
            step();
            chk("pair_idle", txDataEn, 0);
        end

        // Overflow: six writes into a 4-deep FIFO with output stalled.
        txReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rxDataA = 10'h010 + 10'(i); rxDataAEn = 1'b1;
            if (i < 4) expQ.push_back(10'h010 + 10'(i));
            step();
        end
        rxDataAEn = 1'b0;
        chk("ovfl_full", fifoAFull, 1);
        chk("ovfl_cntA", ovflCntA, EXP_OVFL);
        chk("ovfl_cntB", ovflCntB, 0);
        chk("ovfl_stall_en", txDataEn, 0);
        txReady = 1'b1;
        step();
        chk("drain_first", txData, 10'h010);
        chk("drain_notfull", fifoAFull, 0);
        for (int i = 0; i < 5; i++) step();
        chk("drain_done_en", txDataEn, 0);
        chk("drain_last", txData, 10'h013);

        // Full FIFO with write and pop on the same edge.
        txReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rxDataA = 10'h030 + 10'(i); rxDataAEn = 1'b1;
            expQ.push_back(10'h030 + 10'(i));
            step();
        end
        chk("wp_full_before", fifoAFull, 1);
        txReady = 1'b1;
        rxDataA = 10'h020; rxDataAEn = 1'b1;
        expQ.push_back(10'h020);
        step();
        rxDataAEn = 1'b0;
        chk("wp_full_after", fifoAFull, 1);
        chk("wp_ovfl", ovflCntA, EXP_OVFL);
        chk("wp_pop", txData, 10'h030);
        for (int i = 0; i < 6; i++) step();
        chk("wp_last", txData, 10'h020);
        chk("wp_queue_empty", expQ.size(), 0);

        // Reset while three words are buffered.
        txReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rxDataB = 10'h0a0 + 10'(i); rxDataBEn = 1'b1;
            step();
        end
        rxDataBEn = 1'b0;
        do_reset();
        chk_reset_state("rst_mid");
        txReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_mid_quiet", txDataEn, 0);
        end

        chk("final_queue_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cob_timing_arbiter.md
# cob_timing_arbiter

Merges the two COB timing receive streams (A and B) onto the single COB timing transmit port, one word per accepted cycle. Each stream gets its own small FIFO, and a round-robin arbiter shares the output between them under `txReady` flow control. The block sits between the DPM timing receive lanes and the COB timing transmitter, and replaces the plain OR-merge, which corrupts data when both enables fire together.

## Interface
Parameters:
- `DEPTH`, 4: entries per input FIFO; power of two, 2–16.
- `CNT_WIDTH`, 16: width of the overflow counters.

Ports:
- `sysClk125`  in  1  block clock; everything is on this single clock.
- `sysClk125Rst`  in  1  reset; synchronous, active-high.
- `rxDataA`  in  10  stream A word.
- `rxDataAEn`  in  1  stream A word valid (single-cycle strobe, no backpressure).
- `rxDataB`  in  10  stream B word.
- `rxDataBEn`  in  1  stream B word valid.
- `txData`  out  10  merged output word, registered.
- `txDataEn`  out  1  output word valid, registered, one cycle per word.
- `txReady`  in  1  transmitter can take a word this cycle.
- `lastGrantB`  out  1  1 = the most recent pop came from B.
- `fifoAFull`  out  1  A FIFO count == `DEPTH`.
- `fifoBFull`  out  1  B FIFO count == `DEPTH`.
- `ovflCntA`  out  `CNT_WIDTH`  number of dropped A words, saturating.
- `ovflCntB`  out  `CNT_WIDTH`  number of dropped B words, saturating.

## Operation
- **Reset state.** Both FIFOs are empty and pointers are 0. Outputs reset as follows: `txData`=0, `txDataEn`=0, `lastGrantB`=1 (so A wins the first tie), full flags 0, counters 0.
- **Write.** On each edge where `rxDataXEn`=1, the word is written if count < `DEPTH`, or if that same FIFO is popped on the same edge.
  - Otherwise the word is dropped and `ovflCntX` increments, saturating at all-ones.
  - A and B are independent, so both can write on the same edge.
- **Arbitration.** Evaluated every edge using the registered FIFO counts from before the edge.
  - If `txReady`=0, nothing is popped.
  - If only one FIFO is non-empty, that FIFO is popped.
  - If both are non-empty, pop A when `lastGrantB`=1, otherwise pop B.
  - `lastGrantB` updates only when a pop happens.
- **Output.** When a pop happens, `txData` takes the popped word and `txDataEn`=1 on that edge.
  - Otherwise `txDataEn`=0 and `txData` holds its previous value.
  - At most one pop per edge.
- **Ordering.** Each stream comes out in its own arrival order. There is no ordering guarantee between A and B words.
- **Pointers.** Wrap modulo `DEPTH`. Each count is the width of `DEPTH` plus one bit and changes by −1, 0 or +1 per edge.
- **Reset mid-operation.** Reset takes precedence over everything on the same edge. All buffered words are discarded with no output and no counter change.

## Timing
- **Latency.** A word sampled on edge E into an empty FIFO, with `txReady`=1 at edge E+1, is popped at E+1. `txDataEn` is then high in the cycle after E+1, so latency is 2 edges.
- **Throughput.**
  - Sustained: one word per cycle total, with both streams alternating when both are backlogged.
  - Combined input rate above 1 word per cycle is absorbed by the FIFOs until full, then the excess drops.
- **Backpressure.** `txReady` is sampled on the same edge as the pop decision. Any word already presented with `txDataEn`=1 is considered delivered; the transmitter must not depend on it being re-presented.
- **Full flags.** `fifoXFull` is registered and reflects the count after the edge.
- **Write while full.** A write and a pop on a full FIFO on the same edge keeps the count at `DEPTH` and is not counted as an overflow.

## Configuration
- **`COB_ARB_OVFL_CNT_EN` defined:** the overflow counters are built as described in Operation.
- **Not defined:**
  - `ovflCntA` and `ovflCntB` are tied to 0 and the counter logic is removed.
  - The drop behaviour is unchanged.
  - The ports stay present so the instantiation is identical either way.

## Test plan
- **Reset, then a single A word.** With `txReady`=1, one A word 0x155 → `txDataEn` pulses once, 2 edges later, with `txData`=0x155. `lastGrantB`=0.
- **Simultaneous A and B writes.** With `txReady`=1, A=0x001 and B=0x002 together on one edge → outputs 0x001 then 0x002 on consecutive cycles. A second pair then yields 0x001 first again: after B was last granted, A wins the tie.
- **Continuous writes, `DEPTH`=4.** `txReady`=0, then 6 A writes of 0x010–0x015 → `fifoAFull`=1, `ovflCntA`=2. Raising `txReady` then outputs 0x010–0x013 in order.
- **Full with simultaneous write and pop.** A FIFO full, `txReady`=1, one A write → count stays 4 and `ovflCntA` is unchanged.
- **Reset mid-backlog.** `sysClk125Rst` asserted for 1 cycle with 3 words buffered → no `txDataEn` afterwards, and all outputs return to their reset values.
- **Macro off.** Build without `COB_ARB_OVFL_CNT_EN` and rerun the overflow case → `ovflCntA` reads 0 and the same 2 words are still dropped.
